// File: rtl/shift_add_multiplier.sv
// Sequential radix-2 shift-add multiplier with start/busy/done handshake; one iteration per clock.
// Define SHIFT_ADD_MULT_SIGNED_EN for two's-complement operands (last iteration subtracts).
module shift_add_multiplier #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             busy_reg, done_reg;
  logic [WIDTH:0]   sum;
  logic             last_iter;

  assign last_iter = (count_reg == CW'(WIDTH - 1));

`ifdef SHIFT_ADD_MULT_SIGNED_EN
  // Sign-extended partial sum; the multiplier's sign bit carries weight -2^(WIDTH-1).
  logic [WIDTH:0] hi_ext, mcand_ext;
  assign hi_ext    = {hi_reg[WIDTH-1], hi_reg};
  assign mcand_ext = {mcand_reg[WIDTH-1], mcand_reg};

  always_comb begin
    sum = hi_ext;
    if (lo_reg[0]) begin
      if (last_iter) sum = hi_ext - mcand_ext;
      else           sum = hi_ext + mcand_ext;
    end
  end
`else
  always_comb begin
    sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
  end
`endif

  always_comb begin
    state_next = state_reg;
    mcand_next = mcand_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    count_next = count_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          mcand_next = multiplicand;
          hi_next    = '0;
          lo_next    = multiplier;
          count_next = '0;
          state_next = S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_RUN: begin
        // Right shift of {hi, lo}; the carry out lands in the hi MSB.
        hi_next    = sum[WIDTH:1];
        lo_next    = {sum[0], lo_reg[WIDTH-1:1]};
        count_next = count_reg + CW'(1);
        if (last_iter) state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      mcand_reg <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      count_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      mcand_reg <= mcand_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      count_reg <= count_next;
      busy_reg  <= (state_next == S_RUN);
      done_reg  <= (state_next == S_DONE);
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign product_hi = hi_reg;
  assign product_lo = lo_reg;

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential radix-2 shift-add multiplier. It is the multiply-side counterpart of the restoring divider's remainder/quotient register pair.
- A combined {product_hi, product_lo} register shifts RIGHT one bit per cycle, the mirror of the divider's left-shifting {rem, q} pair.
- The multiplier operand occupies product_lo initially and is consumed LSB-first.
- It sits beside the divider in the arithmetic datapath and uses the same start/busy/done handshake style.

Parameters:
- WIDTH, 64, operand width in bits; product is 2*WIDTH bits. Legal range is WIDTH >= 2.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled on rising edge when state is IDLE or DONE
- multiplicand  input  WIDTH  operand A, captured on accepted start
- multiplier  input  WIDTH  operand B, captured on accepted start
- busy  output  1  high while state is RUN
- done  output  1  one-cycle pulse; product is valid while done is high and afterwards
- product_hi  output  WIDTH  upper half of product register
- product_lo  output  WIDTH  lower half of product register

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous and active-high. Reset has priority over every other input.
- Reset values: state=IDLE, busy=0, done=0, product_hi=0, product_lo=0, internal multiplicand register=0, count=0.
- Reset asserted mid-operation aborts the operation. No done pulse is produced for the aborted operation.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- Accepted start (state IDLE or DONE, start=1):
  - mcand_reg <= multiplicand, product_hi <= 0, product_lo <= multiplier, count <= 0, state <= RUN.
  - Accepting start in DONE allows back-to-back operations with no IDLE gap.
- start while in RUN is ignored; operands are not resampled.
- RUN iteration, each edge:
  - sum[WIDTH:0] = {1'b0, product_hi} + (product_lo[0] ? {1'b0, mcand_reg} : 0).
  - product_hi <= sum[WIDTH:1].
  - product_lo <= {sum[0], product_lo[WIDTH-1:1]}.
  - count <= count + 1.
  - The carry out is never lost: it becomes product_hi MSB.
- count is $clog2(WIDTH)+1 bits. When the edge performs iteration count==WIDTH-1, state <= DONE.
- Latency: start sampled at edge k; iterations occur on edges k+1..k+WIDTH; done=1 during the cycle after edge k+WIDTH. Total: WIDTH+1 edges from acceptance to the done-visible cycle.
- DONE -> IDLE on the next edge if start=0.
- Product registers hold their value in IDLE until the next accepted start.
- Arithmetic is unsigned by default. The result is exact for all operand values, with no overflow: the full 2*WIDTH product is produced.
- Outputs are driven directly from registers; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: SHIFT_ADD_MULT_SIGNED_EN.
- Defined: operands are two's complement.
  - Iterations 0..WIDTH-2 add sign-extended mcand_reg to sign-extended product_hi (WIDTH+1 bits).
  - Iteration WIDTH-1 SUBTRACTS mcand_reg when product_lo[0]=1.
  - The shift is arithmetic: the new product_hi MSB is sum[WIDTH] of the sign-extended sum.
  - The result is the signed 2*WIDTH product. Latency is unchanged.
- Undefined: purely unsigned behaviour as described above; no signed logic is synthesized.

Test Plan:
- WIDTH=64, reset, start with A=3, B=5 -> done pulses WIDTH edges after the start edge; product_hi=0, product_lo=15; busy high for exactly 64 cycles.
- A=B=0xFFFF_FFFF_FFFF_FFFF -> product_hi=0xFFFF_FFFF_FFFF_FFFE, product_lo=0x0000_0000_0000_0001, which checks carry into the hi MSB.
- A=0x1234, B=0 and A=0, B=0xABCD -> product 0 in both cases; done timing is identical to non-zero operands.
- Start accepted with A=7, B=9; start pulsed again with A=2, B=2 at cycle 10 of RUN -> result 63, the second start is ignored. Start held high in the DONE cycle with A=6, B=7 -> back-to-back op yields 42.
- Reset asserted at RUN cycle 20 -> next cycle busy=0, done=0, product_hi=product_lo=0; a fresh start with A=4, B=4 yields 16.
- With SHIFT_ADD_MULT_SIGNED_EN defined: A=-3, B=5 -> {hi,lo}=-15, i.e. hi=all ones, lo=0xFFFF_FFFF_FFFF_FFF1. A=-1, B=-1 -> 1. A=0x8000_0000_0000_0000, B=-1 -> hi=0, lo=0x8000_0000_0000_0000.
